// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity mode encodings and
// the baud divider calculation used by both receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clocks per oversample tick, truncated. Users must reject a result
    // below 1 at elaboration (see uart_baud_tick).
    function automatic int calc_div(input int clk_freq, input int baud,
                                    input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every DIV clocks, where
// DIV = CLK_FREQ / (BAUD*OVERSAMPLE). clr realigns the phase to a frame edge.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int CW  = $clog2(DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if (DIV < 1) begin : g_div_check
        $error("uart_baud_tick: CLK_FREQ too low for BAUD*OVERSAMPLE");
    end

    logic [CW-1:0] cnt;

    // Free-running divider, restarted from zero on clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, oversampled mid-bit
// sampling, DATA_BITS payload, optional odd/even parity, framing check.
// Build option UART_RX_MAJORITY_EN: 2-of-3 vote around mid-bit, decided one
// tick later than the single-sample build.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PAR_NONE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4) begin : g_os_check
        $error("uart_rx_param: OVERSAMPLE must be even and >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_check
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_par_check
        $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end

    state_t               state, state_n;
    logic [1:0]           sync;
    logic                 rxs, rxs_prev;
    logic                 tick, clr;
    logic [TW-1:0]        tcnt;
    logic                 sample_pt, bit_val;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad, par_exp;
    logic                 shift_en, par_en;
    logic                 emit_valid, emit_perr, emit_ferr;

    // Synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync     <= 2'b11;
            rxs_prev <= 1'b1;
        end else begin
            sync     <= {sync[0], rxd};
            rxs_prev <= sync[1];
        end
    end

    assign rxs = sync[1];

    uart_baud_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    // Position within the current bit, in ticks; realigned on start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tcnt <= '0;
        else if (clr)
            tcnt <= '0;
        else if (tick)
            tcnt <= (tcnt == T_LAST) ? '0 : tcnt + 1'b1;
    end

`ifdef UART_RX_MAJORITY_EN
    localparam logic [TW-1:0] T_PRE = TW'(OVERSAMPLE / 2 - 2);
    localparam logic [TW-1:0] T_DEC = TW'(OVERSAMPLE / 2);

    logic [1:0] vote;

    // Capture the two early votes; the third is live rxs at decision time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote <= 2'b11;
        end else if (tick) begin
            if (tcnt == T_PRE) vote[0] <= rxs;
            if (tcnt == T_MID) vote[1] <= rxs;
        end
    end

    assign sample_pt = tick && (tcnt == T_DEC);
    assign bit_val   = (vote[0] & vote[1]) | (vote[0] & rxs) | (vote[1] & rxs);
`else
    assign sample_pt = tick && (tcnt == T_MID);
    assign bit_val   = rxs;
`endif

    assign par_exp = (PARITY == PAR_EVEN) ? ^shreg : ~^shreg;

    // Next-state and per-cycle control decode.
    always_comb begin
        state_n    = state;
        clr        = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        emit_valid = 1'b0;
        emit_perr  = 1'b0;
        emit_ferr  = 1'b0;
        case (state)
            IDLE: begin
                if (rxs_prev && !rxs) begin
                    state_n = START;
                    clr     = 1'b1;
                end
            end
            START: begin
                if (sample_pt) state_n = bit_val ? IDLE : DATA;
            end
            DATA: begin
                if (sample_pt) begin
                    shift_en = 1'b1;
                    if (bit_idx == B_LAST)
                        state_n = (PARITY != PAR_NONE) ? PAR : STOP;
                end
            end
            PAR: begin
                if (sample_pt) begin
                    par_en  = 1'b1;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (sample_pt) begin
                    if (!bit_val) begin
                        emit_ferr = 1'b1;
                        state_n   = WAIT_HIGH;
                    end else begin
                        emit_perr  = par_bad;
                        emit_valid = !par_bad;
                        state_n    = IDLE;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, payload assembly and registered result pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            data_valid <= emit_valid;
            parity_err <= emit_perr;
            frame_err  <= emit_ferr;
            if (clr) begin
                bit_idx <= '0;
                par_bad <= 1'b0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
                shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
            end
            if (par_en) par_bad <= (bit_val != par_exp);
            if (emit_valid) data_out <= shreg;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: 8N1 instance on line a, 7E1 instance
// on line b, 16 clocks per bit (DIV = 1).
module tb_uart_rx_param;

    localparam int CF     = 1_600_000;
    localparam int BR     = 100_000;
    localparam int OS     = 16;
    localparam int BITCLK = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int GLITCH_BIT = 4;
`else
    localparam int GLITCH_BIT = -1;
`endif

    typedef struct {
        int kind;   // 0 data_valid, 1 parity_err, 2 frame_err
        int data;   // data_out value required while the pulse is high
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd_a = 1'b1, rxd_b = 1'b1;
    logic [7:0] dout_a;
    logic [6:0] dout_b;
    logic       dv_a, pe_a, fe_a, busy_a;
    logic       dv_b, pe_b, fe_b, busy_b;

    exp_t q_a[$], q_b[$];
    exp_t e_a, e_b;
    int   k_a, k_b;
    int   checks = 0, errors = 0;
    int   busy_cnt_a = 0;

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_FREQ(CF), .BAUD(BR), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .rxd(rxd_a), .data_out(dout_a),
        .data_valid(dv_a), .parity_err(pe_a), .frame_err(fe_a), .busy(busy_a)
    );

    uart_rx_param #(
        .CLK_FREQ(CF), .BAUD(BR), .OVERSAMPLE(OS), .DATA_BITS(7), .PARITY(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .rxd(rxd_b), .data_out(dout_b),
        .data_valid(dv_b), .parity_err(pe_b), .frame_err(fe_b), .busy(busy_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] frame8(input logic [7:0] d, input logic stop);
        return {6'b111111, stop, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame7p(input logic [6:0] d, input logic p,
                                            input logic stop);
        return {6'b111111, stop, p, d, 1'b0};
    endfunction

    // Serialise n frame bits LSB first; optional 1-clk inversion mid-bit.
    task automatic send(input int sel, input logic [15:0] bits, input int n,
                        input int glitch_bit);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < BITCLK; j++) begin
                logic v;
                v = bits[i];
                if (i == glitch_bit && j == 8) v = ~v;
                if (sel == 0) rxd_a = v;
                else          rxd_b = v;
                @(negedge clk);
            end
        end
    endtask

    // Monitor for line a: every pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy_a) busy_cnt_a++;
            if (dv_a || pe_a || fe_a) begin
                chk("a_onehot", int'(dv_a) + int'(pe_a) + int'(fe_a), 1);
                k_a = dv_a ? 0 : (pe_a ? 1 : 2);
                if (q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_pulse: kind %0d data 0x%0h, none expected",
                             k_a, dout_a);
                end else begin
                    e_a = q_a.pop_front();
                    chk("a_kind", k_a, e_a.kind);
                    chk("a_data", int'(dout_a), e_a.data);
                end
            end
        end
    end

    // Monitor for line b.
    always @(negedge clk) begin
        if (!rst && (dv_b || pe_b || fe_b)) begin
            chk("b_onehot", int'(dv_b) + int'(pe_b) + int'(fe_b), 1);
            k_b = dv_b ? 0 : (pe_b ? 1 : 2);
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_pulse: kind %0d data 0x%0h, none expected",
                         k_b, dout_b);
            end else begin
                e_b = q_b.pop_front();
                chk("b_kind", k_b, e_b.kind);
                chk("b_data", int'(dout_b), e_b.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int seen;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dout_a", int'(dout_a), 0);
        chk("rst_dv_a",   int'(dv_a),   0);
        chk("rst_pe_a",   int'(pe_a),   0);
        chk("rst_fe_a",   int'(fe_a),   0);
        chk("rst_busy_a", int'(busy_a), 0);
        chk("rst_dout_b", int'(dout_b), 0);
        chk("rst_busy_b", int'(busy_b), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 8N1 0xA5; busy spans start edge to stop-bit mid-sample (~152 clk)
        b0 = busy_cnt_a;
        q_a.push_back('{0, 'hA5});
        send(0, frame8(8'hA5, 1'b1), 10, -1);
        repeat (32) @(negedge clk);
        seen = busy_cnt_a - b0;
        checks++;
        if (seen < 148 || seen > 160) begin
            errors++;
            $display("FAIL a_busy_len: got %0d cycles, expected 148..160", seen);
        end

        // 7E1: 0x55 has four ones -> even parity bit 0 is good, 1 is bad
        q_b.push_back('{0, 'h55});
        send(1, frame7p(7'h55, 1'b0, 1'b1), 10, -1);
        repeat (32) @(negedge clk);
        q_b.push_back('{1, 'h55});
        send(1, frame7p(7'h55, 1'b1, 1'b1), 10, -1);
        repeat (32) @(negedge clk);
        // 0x03: two ones -> parity 0 good
        q_b.push_back('{0, 'h03});
        send(1, frame7p(7'h03, 1'b0, 1'b1), 10, -1);
        repeat (32) @(negedge clk);

        // Framing error on 0x3C, line held low 40 bits, then 0x81
        q_a.push_back('{2, 'hA5});
        send(0, frame8(8'h3C, 1'b0), 10, -1);
        rxd_a = 1'b0;
        repeat (40 * BITCLK) @(negedge clk);
        chk("a_wait_high_busy", int'(busy_a), 1);
        rxd_a = 1'b1;
        repeat (40) @(negedge clk);
        chk("a_after_break_busy", int'(busy_a), 0);
        q_a.push_back('{0, 'h81});
        send(0, frame8(8'h81, 1'b1), 10, -1);
        repeat (32) @(negedge clk);

        // 5-clk glitch: brief busy, no pulse
        seen = 0;
        rxd_a = 1'b0;
        repeat (5) @(negedge clk);
        rxd_a = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (busy_a) seen = 1;
            @(negedge clk);
        end
        chk("a_glitch_busy_seen", seen, 1);
        chk("a_glitch_busy_end", int'(busy_a), 0);

        // Back-to-back frames
        q_a.push_back('{0, 'h00});
        q_a.push_back('{0, 'hFF});
        q_a.push_back('{0, 'h5A});
        send(0, frame8(8'h00, 1'b1), 10, -1);
        send(0, frame8(8'hFF, 1'b1), 10, -1);
        send(0, frame8(8'h5A, 1'b1), 10, -1);
        repeat (32) @(negedge clk);

        // Reset in the middle of 0x77's payload, then 0x12
        send(0, frame8(8'h77, 1'b1), 4, -1);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("a_midrst_busy", int'(busy_a), 0);
        rxd_a = 1'b1;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("a_postrst_dout", int'(dout_a), 0);
        chk("a_postrst_busy", int'(busy_a), 0);
        q_a.push_back('{0, 'h12});
        send(0, frame8(8'h12, 1'b1), 10, GLITCH_BIT);
        repeat (50) @(negedge clk);

        chk("a_queue_left", q_a.size(), 0);
        chk("b_queue_left", q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
